// File: rtl/clk_tick_gen_if.sv
// Control/status bundle for clk_tick_gen: divisor load, mode, step button
// and the generated slow clock, tick and busy flags.
interface clk_tick_gen_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic [CNT_W-1:0] div_i;
   logic             load_i;
   logic [1:0]       mode_i;
   logic             step_i;
   logic             slow_clk_o;
   logic             tick_o;
   logic             busy_o;

   modport master (
      output div_i, load_i, mode_i, step_i,
      input  slow_clk_o, tick_o, busy_o
   );

   modport slave (
      input  div_i, load_i, mode_i, step_i,
      output slow_clk_o, tick_o, busy_o
   );
endinterface

// File: rtl/clk_tick_gen.sv
// Runtime-loadable slow clock divider with stop / free-run / single-step
// modes, a one-cycle tick on each rising slow edge, and a busy flag per step.
module clk_tick_gen #(
   parameter int unsigned      CNT_W       = 32,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(125_000_000)
) (
   input logic           clk_i,
   input logic           rst_ni,
   clk_tick_gen_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, STEP_HI, STEP_LO} state_t;

   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             slow_q, slow_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             step_meta, step_sync, step_prev;

   logic             step_req;
   logic             load_ok;
   logic             last;

   assign step_req = step_sync & ~step_prev;
   assign load_ok  = bus.load_i && (bus.div_i != '0);
   assign last     = (cnt_q == div_q - CNT_W'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         div_q     <= DEFAULT_DIV;
         slow_q    <= 1'b0;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         step_meta <= 1'b0;
         step_sync <= 1'b0;
         step_prev <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         slow_q    <= slow_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
         step_meta <= bus.step_i;
         step_sync <= step_meta;
         step_prev <= step_sync;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      slow_d  = slow_q;
      tick_d  = 1'b0;
      busy_d  = busy_q;

      if (load_ok) div_d = bus.div_i;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            slow_d = 1'b0;
            busy_d = 1'b0;
            if (bus.mode_i == MODE_RUN) begin
               state_d = RUN;
            end else if (bus.mode_i == MODE_STEP && step_req) begin
               state_d = STEP_HI;
               slow_d  = 1'b1;
               tick_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            // Leaving RUN parks the clock low without a tick.
            if (bus.mode_i != MODE_RUN) begin
               state_d = IDLE;
               cnt_d   = '0;
               slow_d  = 1'b0;
            end else if (load_ok) begin
               cnt_d = '0;
            end else if (last) begin
               cnt_d  = '0;
               slow_d = ~slow_q;
               tick_d = ~slow_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STEP_HI: begin
            if (load_ok) begin
               cnt_d = '0;
            end else if (last) begin
               cnt_d   = '0;
               slow_d  = 1'b0;
               state_d = STEP_LO;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STEP_LO: begin
            if (load_ok) begin
               cnt_d = '0;
            end else if (last) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            slow_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.slow_clk_o = slow_q;
   assign bus.tick_o     = tick_q;
   assign bus.busy_o     = busy_q;

endmodule

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
Parametrised successor to the fixed slow-clock divider, used for FPGA bring-up of the RISC-V core. It generates a 50%-duty slow clock (slow_clk_o) and a one-cycle tick_o enable pulse. The divide ratio is loadable at runtime. Three modes are supported: stop, free-run, and single-step, where each button press yields exactly one slow period. It sits between the board clock/button inputs and the core's clock-enable.

Parameters:
CNT_W, 32, width of the half-period counter and of div_i.
DEFAULT_DIV, 125_000_000, half-period length in clk_i cycles after reset (0.4 Hz at 100 MHz). Must be in 1..2^CNT_W-1.

Ports:
clk_i  input  1  system clock.
rst_ni  input  1  asynchronous active-low reset.
div_i  input  CNT_W  new half-period length in clk_i cycles.
load_i  input  1  one-cycle strobe; captures div_i.
mode_i  input  2  00 = stop, 01 = run, 10 = step, 11 = stop.
step_i  input  1  asynchronous level from push button; rising edge requests one step.
slow_clk_o  output  1  divided clock, registered.
tick_o  output  1  one-cycle pulse, coincident with each 0->1 transition of slow_clk_o.
busy_o  output  1  high while a single step is in progress.

Behaviour:
- Reset (rst_ni = 0, asynchronous):
  - Outputs: slow_clk_o = 0, tick_o = 0, busy_o = 0.
  - Internal: cnt = 0, div_q = DEFAULT_DIV, state = IDLE, step synchronisers = 0.
- Divisor register:
  - load_i = 1 with div_i != 0: div_q <= div_i and cnt <= 0. slow_clk_o keeps its level; the new half-period starts on the next cycle.
  - load_i with div_i == 0 is ignored: div_q and cnt are unchanged.
  - load_i has priority over the count increment in the same cycle.
- Step input:
  - step_i passes through a 2-FF synchroniser, then a third register for edge detection.
  - The step request is the rising edge of the synchronised signal.
- FSM states: IDLE, RUN, STEP_HI, STEP_LO.
- IDLE:
  - cnt is held at 0; slow_clk_o is held at 0.
  - mode_i = 01: go to RUN.
  - mode_i = 10 and step request: go to STEP_HI, set slow_clk_o = 1, pulse tick_o = 1, set busy_o = 1.
- RUN:
  - Each cycle: if cnt == div_q-1, then cnt <= 0 and slow_clk_o toggles. tick_o = 1 on the cycle slow_clk_o goes 0->1. Otherwise cnt++.
  - Period is 2*div_q cycles; high time is exactly div_q cycles.
  - mode_i != 01: go to IDLE with cnt <= 0 and slow_clk_o <= 0. No tick is generated.
- STEP_HI:
  - Counts as in RUN. At cnt == div_q-1: cnt <= 0, slow_clk_o <= 0, go to STEP_LO.
- STEP_LO:
  - Counts as in RUN. At cnt == div_q-1: cnt <= 0, busy_o <= 0, go to IDLE.
- A step always completes (2*div_q cycles) regardless of mode_i changes. mode_i is sampled only in IDLE and RUN.
- Step requests are ignored while busy_o = 1 and in RUN.
- Step latency: step_i stable high before clk edge N gives slow_clk_o = 1 and tick_o = 1 after edge N+2 (3-edge latency). Asynchronous arrival near edge N can add one cycle.
- div_q = 1 in RUN: slow_clk_o toggles every cycle, and tick_o pulses every second cycle.
- load_i during a step: new div_q applies from the current half-period, restarting that half-period at cnt = 0. The step remains 2 half-periods.
- Reset mid-operation: everything returns to reset values immediately. Any pending step is lost.
- The counter never exceeds div_q-1. No wrap-around past 2^CNT_W-1 is possible.

Test Plan:
1. DEFAULT_DIV=4, reset, mode_i=01 -> slow_clk_o high 4 / low 4 cycles. tick_o pulses every 8 cycles, aligned with each rising slow_clk_o. First rise occurs 4 cycles after entering RUN.
2. Running with div=4, pulse load_i with div_i=2 mid high-phase -> current level extends by 2 more cycles from the load. Period then becomes 4. load_i with div_i=0 -> no change in period.
3. mode_i=10, one step_i pulse of 5 cycles -> tick_o pulses after the third edge. slow_clk_o is high 4 cycles, then low 4 cycles. busy_o is high for 8 cycles. No further ticks follow.
4. mode_i=10, second step_i edge while busy_o=1 -> ignored, exactly one period produced. Switch mode_i to 01 mid-step -> step still completes, then RUN starts.
5. RUN with slow_clk_o=1, set mode_i=00 -> slow_clk_o=0 next cycle, no tick. Return to 01 -> clean full period starting low.
6. Assert rst_ni asynchronously mid STEP_HI with div_i=3 loaded -> outputs 0 immediately with no clock edge. div_q returns to DEFAULT_DIV.
